// File: rtl/csa_accum_resolve_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RES = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  localparam int W_DEF = 222;
  localparam int G_DEF = 4;
  localparam int L_DEF = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < value; i++) r = i + 1;
    return r;
  endfunction

  function automatic int acc_width(input int w, input int g);
    return w + g;
  endfunction

  // Top limb absorbs the remainder; its unused high bits are zero padding.
  function automatic int limb_width(input int aw, input int l);
    return (aw + l - 1) / l;
  endfunction

  function automatic int idx_width(input int l);
    return (l > 1) ? clog2(l) : 1;
  endfunction

  // One extra bit so the beat count can saturate at 2^G.
  function automatic int cnt_width(input int g);
    return g + 1;
  endfunction

  localparam int AW_DEF = acc_width(W_DEF, G_DEF);
  localparam int LW_DEF = limb_width(AW_DEF, L_DEF);
  localparam int IW_DEF = idx_width(L_DEF);
  localparam int CW_DEF = cnt_width(G_DEF);

endpackage

// File: rtl/csa_accum_resolve_csa32.sv
// Bitwise 3:2 compressor: sum is the parity, carry is the majority of three words.
module csa32 #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] maj
);

  assign sum = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_resolve.sv
// Carry-save accumulator that folds one signed-by-flag operand per cycle and
// resolves the redundant sum/carry pair limb by limb into a binary result.
module csa_accum_resolve
  import csa_acc_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int G = G_DEF,
  parameter int L = L_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_neg,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W+G-1:0]  out_data,
  output logic            out_ovf
);

  localparam int AW = acc_width(W, G);
  localparam int LW = limb_width(AW, L);
  localparam int PW = L * LW;
  localparam int IW = idx_width(L);
  localparam int CW = cnt_width(G);

  localparam logic [CW-1:0] CNT_MAX  = CW'(1 << G);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << G) - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(L - 1);

  state_t          state, state_next;
  logic [AW-1:0]   sum_q, carry_q;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   idx_q;
  logic            res_c_q;
  logic [PW-1:0]   res_q;

  logic            accept, handshake, last_limb;
  logic [AW-1:0]   x, cs_acc, cs_res, sum_new, carry_new;
  logic [PW-1:0]   s_pad, cs_pad, res_next;
  logic [LW:0]     limb_sum;
  int              limb_base;

  assign accept    = (state == ST_ACC) && in_valid;
  assign handshake = (state == ST_OUT) && out_ready;
  assign last_limb = (idx_q == IDX_LAST);

  // Inverting the operand and injecting in_neg at the always-free carry bit 0
  // together form the two's complement without a separate adder.
  assign x      = {{G{1'b0}}, in_data} ^ {AW{in_neg}};
  assign cs_acc = {carry_q[AW-2:0], in_neg};
  assign cs_res = {carry_q[AW-2:0], 1'b0};

  csa32 #(.N(AW)) u_csa (
    .a   (sum_q),
    .b   (cs_acc),
    .c   (x),
    .sum (sum_new),
    .maj (carry_new)
  );

  assign s_pad  = PW'(sum_q);
  assign cs_pad = PW'(cs_res);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    limb_base = int'(idx_q) * LW;
    limb_sum  = {1'b0, s_pad[limb_base +: LW]} + {1'b0, cs_pad[limb_base +: LW]}
              + (LW + 1)'(res_c_q);
    res_next  = res_q;
    res_next[limb_base +: LW] = limb_sum[LW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_ACC:  if (accept && in_last) state_next = ST_RES;
      ST_RES:  if (last_limb)         state_next = ST_OUT;
      ST_OUT:  if (out_ready)         state_next = ST_ACC;
      default:                        state_next = ST_ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_OUT);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking everywhere so each register samples pre-edge values.
    if (rst) begin
      sum_q    <= '0;
      carry_q  <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      res_c_q  <= 1'b0;
      res_q    <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        sum_q   <= sum_new;
        carry_q <= carry_new;
        if (count_q != CNT_MAX)  count_q <= count_q + CW'(1);
        if (count_q == CNT_LAST) out_ovf <= 1'b1;
        if (in_last) begin
          idx_q   <= '0;
          res_c_q <= 1'b0;
        end
      end
      if (state == ST_RES) begin
        res_q   <= res_next;
        res_c_q <= limb_sum[LW];
        idx_q   <= idx_q + IW'(1);
        // Final carry out of the top limb is dropped: result is mod 2^AW.
        if (last_limb) out_data <= res_next[AW-1:0];
      end
      if (handshake) begin
        sum_q   <= '0;
        carry_q <= '0;
        count_q <= '0;
        out_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Directed bench for csa_accum_resolve at L=3, with L=1 and L=7 copies for latency.
module tb_csa_accum_resolve;

  logic                clk;
  logic                rst;
  logic [221:0]        in_data;
  logic                in_neg;
  logic                in_last;
  logic [2:0]          in_valid_v;
  logic [2:0]          in_ready_v;
  logic [2:0]          out_valid_v;
  logic [2:0]          out_ready_v;
  logic [2:0]          out_ovf_v;
  logic [225:0]        out_data_a [3];

  int checks = 0;
  int errors = 0;

  logic [221:0] p221, ones;
  logic [225:0] e_two, e_m7, e16, e15, hold;

  csa_accum_resolve #(.W(222), .G(4), .L(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data_a[0]), .out_ovf(out_ovf_v[0]));

  csa_accum_resolve #(.W(222), .G(4), .L(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_a[1]), .out_ovf(out_ovf_v[1]));

  csa_accum_resolve #(.W(222), .G(4), .L(7)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_neg(in_neg), .in_last(in_last),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_data(out_data_a[2]), .out_ovf(out_ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [225:0] obs, input logic [225:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the beat is accepted on the following posedge.
  task automatic beat(input int k, input logic [221:0] d, input logic n, input logic l);
    in_valid_v[k] = 1'b1;
    in_data       = d;
    in_neg        = n;
    in_last       = l;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    in_neg        = 1'b0;
    in_last       = 1'b0;
  endtask

  // Entered at the negedge of the first cycle after the last beat (count 1).
  task automatic wait_valid(input int k, input int lat_exp, input string tag);
    int n;
    n = 1;
    while (!out_valid_v[k] && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 226'(n), 226'(lat_exp));
  endtask

  task automatic take(input int k, input logic [225:0] d_exp, input logic ovf_exp,
                      input string tag);
    check({tag, "_data"}, out_data_a[k], d_exp);
    check({tag, "_ovf"}, 226'(out_ovf_v[k]), 226'(ovf_exp));
    out_ready_v[k] = 1'b1;
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    check({tag, "_valid_drop"}, 226'(out_valid_v[k]), 226'(0));
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '0;
    in_data     = '0;
    in_neg      = 1'b0;
    in_last     = 1'b0;
    p221        = '0;
    p221[221]   = 1'b1;
    ones        = '1;
    e_two       = (226'd1 << 222) + 226'd1;
    e_m7        = 226'd0 - 226'd7;
    e16         = 226'd0 - 226'd16;
    e15         = (226'd15 << 222) - 226'd15;

    repeat (2) @(negedge clk);
    check("rst_valid", 226'(out_valid_v[0]), 226'(0));
    check("rst_data", out_data_a[0], 226'(0));
    check("rst_ovf", 226'(out_ovf_v[0]), 226'(0));
    rst = 1'b0;
    check("first_ready", 226'(in_ready_v[0]), 226'(1));

    // Single beat
    beat(0, 222'd5, 1'b0, 1'b1);
    check("res_ready_low", 226'(in_ready_v[0]), 226'(0));
    wait_valid(0, 4, "single5");
    take(0, 226'd5, 1'b0, "single5");

    // Guard bit and cross-limb carries
    beat(0, p221, 1'b0, 1'b0);
    beat(0, p221, 1'b0, 1'b0);
    beat(0, 222'd1, 1'b0, 1'b1);
    wait_valid(0, 4, "guard");
    take(0, e_two, 1'b0, "guard");

    // Subtraction
    beat(0, 222'd10, 1'b0, 1'b0);
    beat(0, 222'd3, 1'b1, 1'b1);
    wait_valid(0, 4, "sub_pos");
    take(0, 226'd7, 1'b0, "sub_pos");
    beat(0, 222'd3, 1'b0, 1'b0);
    beat(0, 222'd10, 1'b1, 1'b1);
    wait_valid(0, 4, "sub_neg");
    take(0, e_m7, 1'b0, "sub_neg");

    // Backpressure with a beat held pending during OUT
    beat(0, 222'd42, 1'b0, 1'b1);
    wait_valid(0, 4, "bp");
    hold          = out_data_a[0];
    in_valid_v[0] = 1'b1;
    in_data       = 222'd100;
    in_last       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 226'(out_valid_v[0]), 226'(1));
      check("bp_data_held", out_data_a[0], hold);
      check("bp_ready_low", 226'(in_ready_v[0]), 226'(0));
      @(negedge clk);
    end
    take(0, 226'd42, 1'b0, "bp");
    check("bp_ready_back", 226'(in_ready_v[0]), 226'(1));
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    in_last       = 1'b0;
    wait_valid(0, 4, "bp_next");
    take(0, 226'd100, 1'b0, "bp_next");

    // Overflow tracking
    for (int i = 0; i < 16; i++) beat(0, ones, 1'b0, i == 15);
    wait_valid(0, 4, "ovf16");
    take(0, e16, 1'b1, "ovf16");
    for (int i = 0; i < 15; i++) beat(0, ones, 1'b0, i == 14);
    wait_valid(0, 4, "ovf15");
    take(0, e15, 1'b0, "ovf15");

    // Reset during RES cycle 2
    beat(0, 222'd7, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 226'(out_valid_v[0]), 226'(0));
    check("midrst_data", out_data_a[0], 226'(0));
    check("midrst_ovf", 226'(out_ovf_v[0]), 226'(0));
    check("midrst_ready", 226'(in_ready_v[0]), 226'(1));
    rst = 1'b0;
    beat(0, 222'd9, 1'b0, 1'b1);
    wait_valid(0, 4, "after_rst");
    take(0, 226'd9, 1'b0, "after_rst");

    // Limb count variants
    beat(1, p221, 1'b0, 1'b0);
    beat(1, p221, 1'b0, 1'b0);
    beat(1, 222'd1, 1'b0, 1'b1);
    wait_valid(1, 2, "l1_guard");
    take(1, e_two, 1'b0, "l1_guard");
    beat(2, p221, 1'b0, 1'b0);
    beat(2, p221, 1'b0, 1'b0);
    beat(2, 222'd1, 1'b0, 1'b1);
    wait_valid(2, 8, "l7_guard");
    take(2, e_two, 1'b0, "l7_guard");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
